// File: rtl/ser2par_demux8_pkg.sv
// Shared types and constants for the ser2par_demux8 serial-to-parallel block.
// Optional parity support is selected with the SER2PAR_PARITY_EN macro.
package ser2par_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

`ifdef SER2PAR_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd3
  } state_t;
`endif

  // Map the arrival index of a bit to its position in the output byte.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx,
                                               input logic             msb_first);
    return msb_first ? (IDX_W'(DATA_W - 1) - idx) : idx;
  endfunction

endpackage

// File: rtl/ser2par_demux8_if.sv
// Bus bundle for ser2par_demux8: serial bit input side and parallel byte output side.
// slave is the block's view, master is the driver/consumer view.
interface ser2par_demux8_if;
  import ser2par_pkg::*;

  logic              in_valid;
  logic              in_bit;
  logic              frame_start;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_err;

  modport slave (
    input  in_valid, in_bit, frame_start, out_ready,
    output in_ready, out_data, out_valid, out_err
  );

  modport master (
    output in_valid, in_bit, frame_start, out_ready,
    input  in_ready, out_data, out_valid, out_err
  );

endinterface

// File: rtl/ser2par_demux8_demux1_8.sv
// 3-bit index plus enable decoded to a one-hot 8-bit write enable.
module demux1_8
  import ser2par_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_we
);

  // One-hot decode of the selected bit position, all zero when disabled.
  always_comb begin
    o_we = '0;
    if (i_en) o_we[i_idx] = 1'b1;
  end

endmodule

// File: rtl/ser2par_demux8.sv
// Serial-to-parallel byte assembler. Bits are accepted on in_valid && in_ready,
// a frame begins on a bit flagged frame_start, and each bit is steered into the
// output byte through a one-hot demux. The completed byte is held on out_data
// with out_valid until the consumer takes it.
// MSB_FIRST selects whether the first bit lands in bit 0 or bit 7.
// Optional macro SER2PAR_PARITY_EN adds a trailing even-parity bit per frame and
// drives out_err; without it out_err is tied low.
module ser2par_demux8
  import ser2par_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
)(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  ser2par_demux8_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] r_data;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_wr_pos;
  logic [DATA_W-1:0] w_we;
`ifdef SER2PAR_PARITY_EN
  logic              r_err;
  logic              w_err_ld;
`endif

  assign w_in_ready = (r_state != ST_HOLD);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_wr_pos   = bit_pos(w_wr_idx, MSB_FIRST);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.out_data  = r_data;
`ifdef SER2PAR_PARITY_EN
  assign bus.out_err   = r_err;
`else
  assign bus.out_err   = 1'b0;
`endif

  demux1_8 u_demux (
    .i_idx (w_wr_pos),
    .i_en  (w_wr_en),
    .o_we  (w_we)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state, bit index and write-enable decisions for each accepted bit.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_idx;
`ifdef SER2PAR_PARITY_EN
    w_err_ld    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept && bus.frame_start) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = '0;
          w_idx_nxt   = IDX_W'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (bus.frame_start) begin
            // Restart: the partial byte is abandoned and this bit becomes bit 0.
            w_wr_idx  = '0;
            w_idx_nxt = IDX_W'(1);
          end else begin
            w_wr_idx  = r_idx;
            w_idx_nxt = r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(DATA_W - 1)) begin
`ifdef SER2PAR_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_HOLD;
`endif
            end
          end
        end
      end
`ifdef SER2PAR_PARITY_EN
      ST_PARITY: begin
        if (w_accept) begin
          if (bus.frame_start) begin
            w_wr_en     = 1'b1;
            w_wr_idx    = '0;
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = ST_SHIFT;
          end else begin
            w_err_ld    = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = ST_HOLD;
          end
        end
      end
`endif
      ST_HOLD: begin
        if (bus.out_ready) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arrival index of the next bit within the frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_idx <= '0;
    else            r_idx <= w_idx_nxt;
  end

  // Byte register: only the demux-selected bit is written by an accepted bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data <= '0;
    end else begin
      for (int i = 0; i < DATA_W; i++) begin
        if (w_we[i]) r_data[i] <= bus.in_bit;
      end
    end
  end

`ifdef SER2PAR_PARITY_EN
  // Even-parity check: flag is set when byte XOR parity bit is odd.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    r_err <= 1'b0;
    else if (w_err_ld) r_err <= (^r_data) ^ bus.in_bit;
  end
`endif

endmodule

// File: tb/tb_ser2par_demux8.sv
// Testbench for ser2par_demux8: two instances (LSB-first and MSB-first) share
// the same stimulus; a frame-level reference model predicts the handshake,
// byte and error outputs. Works with or without SER2PAR_PARITY_EN.
`timescale 1ns/1ps
module tb_ser2par_demux8;
  import ser2par_pkg::*;

`ifdef SER2PAR_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  always #5 sys_clk = ~sys_clk;

  ser2par_demux8_if if_lsb ();
  ser2par_demux8_if if_msb ();

  ser2par_demux8 #(.MSB_FIRST(1'b0)) u_lsb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (if_lsb.slave)
  );

  ser2par_demux8 #(.MSB_FIRST(1'b1)) u_msb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (if_msb.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: bits of the frame in progress (empty when no frame open),
  // whether a completed byte is being offered, and what that byte looks like.
  bit       m_bits[$];
  bit       m_hold;
  bit [7:0] m_byte_lsb;
  bit [7:0] m_byte_msb;
  bit       m_err;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_hold = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit fs, input bit rdy);
    if (m_hold) begin
      if (rdy) m_hold = 1'b0;
    end else if (v) begin
      if (fs) begin
        m_bits.delete();
        m_bits.push_back(b);
      end else if (m_bits.size() > 0) begin
        m_bits.push_back(b);
      end
      if (m_bits.size() == FRAME_LEN) begin
        for (int i = 0; i < 8; i++) begin
          m_byte_lsb[i]     = m_bits[i];
          m_byte_msb[7 - i] = m_bits[i];
        end
        m_err = 1'b0;
`ifdef SER2PAR_PARITY_EN
        for (int i = 0; i < FRAME_LEN; i++) m_err = m_err ^ m_bits[i];
`endif
        m_hold = 1'b1;
        m_bits.delete();
      end
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit fs, input bit rdy);
    if_lsb.in_valid = v;  if_lsb.in_bit = b;  if_lsb.frame_start = fs;  if_lsb.out_ready = rdy;
    if_msb.in_valid = v;  if_msb.in_bit = b;  if_msb.frame_start = fs;  if_msb.out_ready = rdy;
  endtask

  task automatic check_all();
    check("in_ready_lsb",  8'(if_lsb.in_ready),  8'(!m_hold));
    check("in_ready_msb",  8'(if_msb.in_ready),  8'(!m_hold));
    check("out_valid_lsb", 8'(if_lsb.out_valid), 8'(m_hold));
    check("out_valid_msb", 8'(if_msb.out_valid), 8'(m_hold));
    if (m_hold) begin
      check("out_data_lsb", if_lsb.out_data, m_byte_lsb);
      check("out_data_msb", if_msb.out_data, m_byte_msb);
      check("out_err_lsb",  8'(if_lsb.out_err), 8'(m_err));
      check("out_err_msb",  8'(if_msb.out_err), 8'(m_err));
    end
  endtask

  task automatic cycle(input bit v, input bit b, input bit fs, input bit rdy);
    @(negedge sys_clk);
    drive(v, b, fs, rdy);
    model_step(v, b, fs, rdy);
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  // Sends one frame: 8 data bits in arrival order val[0]..val[7], frame_start
  // on the first, followed by the parity bit when parity is enabled.
  task automatic send_byte(input bit [7:0] val, input bit par, input bit rdy);
    for (int i = 0; i < 8; i++) cycle(1'b1, val[i], (i == 0), rdy);
`ifdef SER2PAR_PARITY_EN
    cycle(1'b1, par, 1'b0, rdy);
`else
    if (par) begin end
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_lsb"},  if_lsb.out_data, 8'h00);
    check({tag, "_data_msb"},  if_msb.out_data, 8'h00);
    check({tag, "_valid"},     8'(if_lsb.out_valid | if_msb.out_valid), 8'h00);
    check({tag, "_err"},       8'(if_lsb.out_err | if_msb.out_err), 8'h00);
    check({tag, "_in_ready"},  8'(if_lsb.in_ready & if_msb.in_ready), 8'h01);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_reset_values("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Basic frame 1,0,1,1,0,0,1,0 with consumer always ready.
    send_byte(8'h4D, 1'b0, 1'b1);
    check("f1_valid",    8'(if_lsb.out_valid), 8'h01);
    check("f1_data_lsb", if_lsb.out_data, 8'h4D);
    check("f1_data_msb", if_msb.out_data, 8'hB2);
    check("f1_err",      8'(if_lsb.out_err), 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("f1_valid_drop", 8'(if_lsb.out_valid), 8'h00);
    check("f1_ready_back", 8'(if_lsb.in_ready), 8'h01);

    // Consumer stalls while the producer keeps pushing bits (with frame_start).
    send_byte(8'h4D, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'b1, 1'b0);
    check("stall_in_ready", 8'(if_lsb.in_ready), 8'h00);
    check("stall_data_lsb", if_lsb.out_data, 8'h4D);
    check("stall_data_msb", if_msb.out_data, 8'hB2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("stall_release_valid", 8'(if_lsb.out_valid), 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Partial frame of four bits abandoned by a new frame_start.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, (i == 0), 1'b1);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("restart_data_lsb", if_lsb.out_data, 8'hFF);
    check("restart_data_msb", if_msb.out_data, 8'hFF);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SER2PAR_PARITY_EN
    // Wrong parity bit for 8'h4D raises the error flag.
    send_byte(8'h4D, 1'b1, 1'b0);
    check("parity_err", 8'(if_lsb.out_err), 8'h01);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Reset pulse in the middle of a frame.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, (i == 0), 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("midrst_no_valid", 8'(if_lsb.out_valid | if_msb.out_valid), 8'h00);
    send_byte(8'hA5, 1'b0, 1'b1);
    check("midrst_data_lsb", if_lsb.out_data, 8'hA5);
    check("midrst_data_msb", if_msb.out_data, 8'hA5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
